// File: rtl/matmul_operand_feeder_if.sv
// Bundles the control, host, result and stream signals of the matmul operand feeder.
// Signal suffixes are named from the feeder's point of view.
interface matmul_operand_feeder_if #(
   parameter int BUS_WIDTH  = 16,
   parameter int ADDR_WIDTH = 32
);
   // control
   logic                  start_i;
   logic [1:0]            n_dim_i;
   logic [1:0]            k_dim_i;
   logic [1:0]            m_dim_i;
   // host write / read port
   logic                  wr_en_i;
   logic [ADDR_WIDTH-1:0] wr_addr_i;
   logic [BUS_WIDTH-1:0]  wr_data_i;
   logic                  rd_en_i;
   logic [ADDR_WIDTH-1:0] rd_addr_i;
   logic [BUS_WIDTH-1:0]  rd_data_o;
   // result write-back from the calculation stage
   logic                  res_en_i;
   logic [ADDR_WIDTH-1:0] res_addr_i;
   logic [BUS_WIDTH-1:0]  res_data_i;
   logic                  finish_i;
   // stream towards the calculation stage and status
   logic                  start_o;
   logic [BUS_WIDTH-1:0]  data_a_o;
   logic [BUS_WIDTH-1:0]  data_b_o;
   logic [BUS_WIDTH-1:0]  data_c_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  wr_err_o;

   // host / control / calc-stage side
   modport master (
      output start_i, n_dim_i, k_dim_i, m_dim_i,
      output wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
      output res_en_i, res_addr_i, res_data_i, finish_i,
      input  rd_data_o, start_o, data_a_o, data_b_o, data_c_o,
      input  busy_o, done_o, wr_err_o
   );

   // feeder side
   modport slave (
      input  start_i, n_dim_i, k_dim_i, m_dim_i,
      input  wr_en_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
      input  res_en_i, res_addr_i, res_data_i, finish_i,
      output rd_data_o, start_o, data_a_o, data_b_o, data_c_o,
      output busy_o, done_o, wr_err_o
   );
endinterface

// File: rtl/matmul_operand_feeder.sv
// Operand staging buffer in front of the matmul calculation stage.
// Holds A rows, B columns and the C bias/result matrix, streams them one word
// per cycle on a run request and absorbs C result write-back from the calc stage.
module matmul_operand_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   matmul_operand_feeder_if.slave   bus
);
   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int C_WORDS = MAX_DIM * MAX_DIM;
   localparam int IW      = 2 * $clog2(MAX_DIM);
   localparam int ICW     = $clog2(C_WORDS + 1);   // ic counts up to C_WORDS
   localparam int ICP     = ICW + 1;               // room for ic+1

   typedef enum logic [1:0] {TGT_NONE, TGT_A, TGT_B, TGT_C} tgt_e;
   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_e;

   function automatic tgt_e decode_tgt(input logic [4:0] code);
      case (code)
         5'b00100: decode_tgt = TGT_A;
         5'b01000: decode_tgt = TGT_B;
         5'b10000: decode_tgt = TGT_C;
         default:  decode_tgt = TGT_NONE;
      endcase
   endfunction

   // ---------------------------------------------------------------- storage
   logic [BUS_WIDTH-1:0] a_mem [MAX_DIM];
   logic [BUS_WIDTH-1:0] b_mem [MAX_DIM];
   logic [BUS_WIDTH-1:0] c_mem [C_WORDS];

   // ---------------------------------------------------------------- state
   state_e               state_q;
   logic                 start_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 hold_q;     // run completed, wait for start_i to drop
   logic                 wr_err_q;
   logic [1:0]           ia_q;
   logic [1:0]           ib_q;
   logic [ICW-1:0]       ic_q;
   logic [BUS_WIDTH-1:0] data_a_q;
   logic [BUS_WIDTH-1:0] data_b_q;
   logic [BUS_WIDTH-1:0] data_c_q;
   logic [BUS_WIDTH-1:0] rd_data_q;

   // ---------------------------------------------------------------- decode
   tgt_e          wr_tgt, rd_tgt, res_tgt;
   logic [IW-1:0] wr_idx, rd_idx, res_idx;
   logic          res_ok;
   logic          wr_in_range;
   logic          wr_clash;
   logic          wr_ok;
   logic          wr_rej;

   assign wr_tgt  = decode_tgt(bus.wr_addr_i[4:0]);
   assign rd_tgt  = decode_tgt(bus.rd_addr_i[4:0]);
   assign res_tgt = decode_tgt(bus.res_addr_i[4:0]);
   assign wr_idx  = bus.wr_addr_i[5 +: IW];
   assign rd_idx  = bus.rd_addr_i[5 +: IW];
   assign res_idx = bus.res_addr_i[5 +: IW];

   // Upper address bits and k are not needed by the feeder itself.
   logic unused_bits;
   assign unused_bits = ^{bus.k_dim_i,
                          bus.wr_addr_i[ADDR_WIDTH-1:5+IW],
                          bus.rd_addr_i[ADDR_WIDTH-1:5+IW],
                          bus.res_addr_i[ADDR_WIDTH-1:5+IW]};

   // Accept/reject decision for host and result writes; result wins a C-index clash.
   always_comb begin
      res_ok      = bus.res_en_i && (res_tgt == TGT_C) && (int'(res_idx) < C_WORDS);
      wr_in_range = 1'b0;
      case (wr_tgt)
         TGT_A:   wr_in_range = int'(wr_idx) < MAX_DIM;
         TGT_B:   wr_in_range = int'(wr_idx) < MAX_DIM;
         TGT_C:   wr_in_range = int'(wr_idx) < C_WORDS;
         default: wr_in_range = 1'b0;
      endcase
      wr_clash = res_ok && (wr_tgt == TGT_C) && (wr_idx == res_idx);
      wr_ok    = bus.wr_en_i && !busy_q && wr_in_range && !wr_clash;
      wr_rej   = bus.wr_en_i && !wr_ok;
   end

   // ---------------------------------------------------------------- storage words
   genvar gi;
   generate
      for (gi = 0; gi < MAX_DIM; gi++) begin : g_ab
         logic [BUS_WIDTH-1:0] a_word_q;
         logic [BUS_WIDTH-1:0] b_word_q;
         // A/B word: host write only
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               a_word_q <= '0;
               b_word_q <= '0;
            end else begin
               if (wr_ok && wr_tgt == TGT_A && wr_idx == IW'(gi)) a_word_q <= bus.wr_data_i;
               if (wr_ok && wr_tgt == TGT_B && wr_idx == IW'(gi)) b_word_q <= bus.wr_data_i;
            end
         end
         assign a_mem[gi] = a_word_q;
         assign b_mem[gi] = b_word_q;
      end

      for (gi = 0; gi < C_WORDS; gi++) begin : g_c
         logic [BUS_WIDTH-1:0] c_word_q;
         // C word: calc-stage result write takes priority over the host
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               c_word_q <= '0;
            end else if (res_ok && res_idx == IW'(gi)) begin
               c_word_q <= bus.res_data_i;
            end else if (wr_ok && wr_tgt == TGT_C && wr_idx == IW'(gi)) begin
               c_word_q <= bus.wr_data_i;
            end
         end
         assign c_mem[gi] = c_word_q;
      end
   endgenerate

   // ---------------------------------------------------------------- host read
   logic [BUS_WIDTH-1:0] rd_val;

   // Host read mux; unknown target or out-of-range index reads as zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         if (rd_tgt == TGT_A && rd_idx == IW'(i)) rd_val = a_mem[i];
         if (rd_tgt == TGT_B && rd_idx == IW'(i)) rd_val = b_mem[i];
      end
      for (int i = 0; i < C_WORDS; i++) begin
         if (rd_tgt == TGT_C && rd_idx == IW'(i)) rd_val = c_mem[i];
      end
   end

   // Registered read data, held while no read is requested; write reject pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
         wr_err_q  <= 1'b0;
      end else begin
         if (bus.rd_en_i) rd_data_q <= rd_val;
         wr_err_q <= wr_rej;
      end
   end

   // ---------------------------------------------------------------- stream lookahead
   logic [2:0]           ia_p1, ib_p1;
   logic [ICP-1:0]       ic_p1;
   int                   c_last;
   logic [BUS_WIDTH-1:0] a_nxt, b_nxt, c_nxt;

   // Next word for each stream: the element after the current counter, or 0 past the edge.
   always_comb begin
      ia_p1  = {1'b0, ia_q} + 3'd1;
      ib_p1  = {1'b0, ib_q} + 3'd1;
      ic_p1  = {1'b0, ic_q} + ICP'(1);
      c_last = (int'(bus.n_dim_i) + 1) * (int'(bus.m_dim_i) + 1) - 1;
      a_nxt  = '0;
      b_nxt  = '0;
      c_nxt  = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         if (ia_p1 == 3'(i) && ia_p1 <= {1'b0, bus.n_dim_i}) a_nxt = a_mem[i];
         if (ib_p1 == 3'(i) && ib_p1 <= {1'b0, bus.m_dim_i}) b_nxt = b_mem[i];
      end
      for (int i = 0; i < C_WORDS; i++) begin
         if (ic_p1 == ICP'(i) && int'(ic_p1) <= c_last) c_nxt = c_mem[i];
      end
   end

   // ---------------------------------------------------------------- control FSM
   // Run sequencing with registered start/busy/done and stream outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hold_q   <= 1'b0;
         ia_q     <= '0;
         ib_q     <= '0;
         ic_q     <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
         data_c_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (!bus.start_i) hold_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start_i && !hold_q) begin
                  state_q  <= S_STREAM;
                  start_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  ia_q     <= '0;
                  ib_q     <= '0;
                  ic_q     <= '0;
                  data_a_q <= a_mem[0];
                  data_b_q <= b_mem[0];
                  data_c_q <= c_mem[0];
               end
            end
            S_STREAM: begin
               if (bus.finish_i) begin
                  state_q  <= S_FLUSH;
                  start_q  <= 1'b0;
                  done_q   <= 1'b1;
                  hold_q   <= 1'b1;
                  data_a_q <= '0;
                  data_b_q <= '0;
                  data_c_q <= '0;
               end else if (!bus.start_i) begin
                  // abort: straight back to idle, no completion pulse
                  state_q  <= S_IDLE;
                  start_q  <= 1'b0;
                  busy_q   <= 1'b0;
                  data_a_q <= '0;
                  data_b_q <= '0;
                  data_c_q <= '0;
               end else begin
                  ia_q     <= (ia_q == 2'd3) ? ia_q : ia_q + 2'd1;
                  ib_q     <= (ib_q == 2'd3) ? ib_q : ib_q + 2'd1;
                  ic_q     <= (ic_q == ICW'(C_WORDS)) ? ic_q : ic_q + ICW'(1);
                  data_a_q <= a_nxt;
                  data_b_q <= b_nxt;
                  data_c_q <= c_nxt;
               end
            end
            S_FLUSH: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               start_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rd_data_o = rd_data_q;
   assign bus.start_o   = start_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.wr_err_o  = wr_err_q;
   assign bus.data_a_o  = data_a_q;
   assign bus.data_b_o  = data_b_q;
   assign bus.data_c_o  = data_c_q;
endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Directed bench for matmul_operand_feeder: load, stream, abort, collision, reject, reset.
module tb_matmul_operand_feeder;
   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   matmul_operand_feeder_if #(.BUS_WIDTH(16), .ADDR_WIDTH(32)) bus_if ();

   matmul_operand_feeder #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if)
   );

   always #5 clk = ~clk;

   localparam logic [4:0] CODE_A = 5'b00100;
   localparam logic [4:0] CODE_B = 5'b01000;
   localparam logic [4:0] CODE_C = 5'b10000;

   function automatic logic [31:0] mk_addr(input logic [4:0] code, input int idx);
      mk_addr = {25'(idx), 2'b00, code} >> 2;
      mk_addr = (32'(idx) << 5) | {27'd0, code};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic host_wr(input logic [31:0] addr, input logic [15:0] data);
      bus_if.wr_en_i   = 1'b1;
      bus_if.wr_addr_i = addr;
      bus_if.wr_data_i = data;
      tick();
      bus_if.wr_en_i   = 1'b0;
   endtask

   task automatic host_rd(input string tag, input logic [31:0] addr, input logic [15:0] exp);
      bus_if.rd_en_i   = 1'b1;
      bus_if.rd_addr_i = addr;
      tick();
      bus_if.rd_en_i   = 1'b0;
      chk(tag, 32'(bus_if.rd_data_o), 32'(exp));
      $display("read  addr=%h data=%h", addr, bus_if.rd_data_o);
   endtask

   initial begin
      rst_n              = 1'b0;
      bus_if.start_i     = 1'b0;
      bus_if.n_dim_i     = 2'd0;
      bus_if.k_dim_i     = 2'd0;
      bus_if.m_dim_i     = 2'd0;
      bus_if.wr_en_i     = 1'b0;
      bus_if.wr_addr_i   = '0;
      bus_if.wr_data_i   = '0;
      bus_if.rd_en_i     = 1'b0;
      bus_if.rd_addr_i   = '0;
      bus_if.res_en_i    = 1'b0;
      bus_if.res_addr_i  = '0;
      bus_if.res_data_i  = '0;
      bus_if.finish_i    = 1'b0;

      // reset state
      #3;
      chk("rst_start", 32'(bus_if.start_o), 32'd0);
      chk("rst_busy",  32'(bus_if.busy_o), 32'd0);
      chk("rst_done",  32'(bus_if.done_o), 32'd0);
      chk("rst_werr",  32'(bus_if.wr_err_o), 32'd0);
      chk("rst_rd",    32'(bus_if.rd_data_o), 32'd0);
      chk("rst_c",     32'(bus_if.data_c_o), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // load operands
      host_wr(mk_addr(CODE_A, 0), 16'h0201);
      chk("wr_ok_err", 32'(bus_if.wr_err_o), 32'd0);
      host_wr(mk_addr(CODE_A, 1), 16'h0403);
      host_wr(mk_addr(CODE_B, 0), 16'h0605);
      host_wr(mk_addr(CODE_B, 1), 16'h0807);
      for (int i = 0; i < 4; i++) host_wr(mk_addr(CODE_C, i), 16'(i + 1));
      $display("load  A/B/C written");

      // run 1: n=m=1, normal completion
      bus_if.n_dim_i = 2'd1;
      bus_if.k_dim_i = 2'd1;
      bus_if.m_dim_i = 2'd1;
      bus_if.start_i = 1'b1;
      tick();
      chk("r1_start", 32'(bus_if.start_o), 32'd1);
      chk("r1_busy",  32'(bus_if.busy_o), 32'd1);
      chk("r1_a0", 32'(bus_if.data_a_o), 32'h0201);
      chk("r1_b0", 32'(bus_if.data_b_o), 32'h0605);
      chk("r1_c0", 32'(bus_if.data_c_o), 32'h0001);
      tick();
      chk("r1_a1", 32'(bus_if.data_a_o), 32'h0403);
      chk("r1_b1", 32'(bus_if.data_b_o), 32'h0807);
      chk("r1_c1", 32'(bus_if.data_c_o), 32'h0002);
      tick();
      chk("r1_a2", 32'(bus_if.data_a_o), 32'h0000);
      chk("r1_b2", 32'(bus_if.data_b_o), 32'h0000);
      chk("r1_c2", 32'(bus_if.data_c_o), 32'h0003);
      tick();
      chk("r1_c3", 32'(bus_if.data_c_o), 32'h0004);
      tick();
      chk("r1_c4", 32'(bus_if.data_c_o), 32'h0000);
      chk("r1_start_hold", 32'(bus_if.start_o), 32'd1);
      bus_if.finish_i = 1'b1;
      tick();
      bus_if.finish_i = 1'b0;
      chk("r1_fin_start", 32'(bus_if.start_o), 32'd0);
      chk("r1_fin_done",  32'(bus_if.done_o), 32'd1);
      chk("r1_fin_busy",  32'(bus_if.busy_o), 32'd1);
      tick();
      chk("r1_idle_busy", 32'(bus_if.busy_o), 32'd0);
      chk("r1_idle_done", 32'(bus_if.done_o), 32'd0);
      tick();
      tick();
      chk("r1_no_restart", 32'(bus_if.start_o), 32'd0);
      chk("r1_no_rbusy",   32'(bus_if.busy_o), 32'd0);
      $display("run1  n=1 m=1 complete");
      bus_if.start_i = 1'b0;
      tick();

      // run 2: n=0 m=1, then abort
      bus_if.n_dim_i = 2'd0;
      bus_if.start_i = 1'b1;
      tick();
      chk("r2_a0", 32'(bus_if.data_a_o), 32'h0201);
      chk("r2_c0", 32'(bus_if.data_c_o), 32'h0001);
      tick();
      chk("r2_a1", 32'(bus_if.data_a_o), 32'h0000);
      chk("r2_b1", 32'(bus_if.data_b_o), 32'h0807);
      chk("r2_c1", 32'(bus_if.data_c_o), 32'h0002);
      tick();
      chk("r2_b2", 32'(bus_if.data_b_o), 32'h0000);
      chk("r2_c2", 32'(bus_if.data_c_o), 32'h0000);
      bus_if.start_i = 1'b0;
      tick();
      chk("r2_abort_start", 32'(bus_if.start_o), 32'd0);
      chk("r2_abort_busy",  32'(bus_if.busy_o), 32'd0);
      chk("r2_abort_done",  32'(bus_if.done_o), 32'd0);
      tick();
      chk("r2_abort_done2", 32'(bus_if.done_o), 32'd0);
      $display("run2  n=0 m=1 aborted");

      // run 3: host write rejected while busy, result write lands in C[2]
      bus_if.n_dim_i = 2'd1;
      bus_if.start_i = 1'b1;
      tick();
      tick();
      bus_if.wr_en_i    = 1'b1;
      bus_if.wr_addr_i  = mk_addr(CODE_A, 0);
      bus_if.wr_data_i  = 16'hFFFF;
      bus_if.res_en_i   = 1'b1;
      bus_if.res_addr_i = mk_addr(CODE_C, 2);
      bus_if.res_data_i = 16'h00AA;
      tick();
      bus_if.wr_en_i  = 1'b0;
      bus_if.res_en_i = 1'b0;
      chk("r3_busy_werr", 32'(bus_if.wr_err_o), 32'd1);
      tick();
      chk("r3_werr_pulse", 32'(bus_if.wr_err_o), 32'd0);
      bus_if.finish_i = 1'b1;
      tick();
      bus_if.finish_i = 1'b0;
      bus_if.start_i  = 1'b0;
      tick();
      tick();
      $display("run3  busy write rejected, result written");
      host_rd("r3_rd_a0", mk_addr(CODE_A, 0), 16'h0201);
      host_rd("r3_rd_c2", mk_addr(CODE_C, 2), 16'h00AA);
      tick();
      chk("rd_hold", 32'(bus_if.rd_data_o), 32'h00AA);

      // same-cycle host and result write to the same C index: result wins
      bus_if.wr_en_i    = 1'b1;
      bus_if.wr_addr_i  = mk_addr(CODE_C, 1);
      bus_if.wr_data_i  = 16'h1111;
      bus_if.res_en_i   = 1'b1;
      bus_if.res_addr_i = mk_addr(CODE_C, 1);
      bus_if.res_data_i = 16'h2222;
      tick();
      bus_if.wr_en_i  = 1'b0;
      bus_if.res_en_i = 1'b0;
      chk("clash_werr", 32'(bus_if.wr_err_o), 32'd1);
      host_rd("clash_rd_c1", mk_addr(CODE_C, 1), 16'h2222);

      // rejected host writes: unknown code, A index out of range
      host_wr(32'h0000_0003, 16'hDEAD);
      chk("bad_code_werr", 32'(bus_if.wr_err_o), 32'd1);
      host_wr(mk_addr(CODE_A, 2), 16'hBEEF);
      chk("bad_idx_werr", 32'(bus_if.wr_err_o), 32'd1);
      host_rd("bad_code_rd", 32'h0000_0003, 16'h0000);
      host_rd("bad_idx_rd",  mk_addr(CODE_A, 2), 16'h0000);
      host_rd("pre_rst_rd",  mk_addr(CODE_A, 0), 16'h0201);

      // asynchronous reset in the middle of a stream
      bus_if.start_i = 1'b1;
      tick();
      tick();
      chk("r4_start", 32'(bus_if.start_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_start", 32'(bus_if.start_o), 32'd0);
      chk("arst_busy",  32'(bus_if.busy_o), 32'd0);
      chk("arst_a",     32'(bus_if.data_a_o), 32'd0);
      chk("arst_b",     32'(bus_if.data_b_o), 32'd0);
      chk("arst_rd",    32'(bus_if.rd_data_o), 32'd0);
      $display("run4  async reset mid-stream");
      bus_if.start_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      host_rd("arst_mem_a0", mk_addr(CODE_A, 0), 16'h0000);
      host_rd("arst_mem_c2", mk_addr(CODE_C, 2), 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/matmul_operand_feeder.md
Name: matmul_operand_feeder

Overview:
- Operand staging buffer directly upstream of the matmul calculation stage.
- Holds operand A rows, operand B columns and the C bias/result matrix, all written and read over a host port.
- On a start request it streams A, B and C to the calculation stage one word per cycle, with its own start_o, in the order the calculation stage samples them.
- Also absorbs the calculation stage's C result writes, so a following accumulate-mode run sees the previous C.

Parameters:
- DATA_WIDTH, 8, element width.
- BUS_WIDTH, 16, word width.
- ADDR_WIDTH, 32, address width.
- Local MAX_DIM = BUS_WIDTH/DATA_WIDTH.
- Local IW = 2*$clog2(MAX_DIM), the index field width.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  run request from control, level
- n_dim_i, k_dim_i, m_dim_i  in  2 each  dimension minus 1 (A is (n+1)x(k+1), B is (k+1)x(m+1))
- wr_en_i  in  1  host write strobe
- wr_addr_i  in  ADDR_WIDTH  host write address
- wr_data_i  in  BUS_WIDTH  host write data
- rd_en_i  in  1  host read strobe
- rd_addr_i  in  ADDR_WIDTH  host read address
- rd_data_o  out  BUS_WIDTH  host read data, 1-cycle latency
- res_en_i  in  1  result write strobe from the calc stage
- res_addr_i  in  ADDR_WIDTH  result address
- res_data_i  in  BUS_WIDTH  result data
- finish_i  in  1  calc stage finished writing C
- start_o  out  1  start to the calc stage
- data_a_o, data_b_o, data_c_o  out  BUS_WIDTH each  streamed words
- busy_o  out  1  stream in progress
- done_o  out  1  one-cycle pulse at normal completion
- wr_err_o  out  1  one-cycle pulse when a host write is rejected

Behaviour:
- Address decode: addr[4:0] selects the target.
  - 5'b00100 selects A; 5'b01000 selects B; 5'b10000 selects C.
  - Index = addr[5 +: IW].
  - A and B hold MAX_DIM words each; C holds MAX_DIM*MAX_DIM words.
- Reset values: all storage, outputs, counters and state are 0; state is IDLE.
- Host write:
  - Accepted when wr_en_i=1 and busy_o=0; storage updates at the clock edge.
  - Rejected (no state change, wr_err_o=1 on the next cycle) when any of these holds:
    - busy_o=1;
    - the target code is unknown;
    - the A or B index is >= MAX_DIM.
- Result write: accepted in any state when res_en_i=1, target code is C and index < MAX_DIM*MAX_DIM; anything else is silently dropped.
- Same-cycle host write and result write to the same C index: the result write wins and the host write is rejected.
- Host read: rd_data_o is registered one cycle after rd_en_i. An unknown target or out-of-range index returns 0. When rd_en_i=0, rd_data_o holds its value.
- FSM has three states: IDLE, STREAM, FLUSH.
- IDLE -> STREAM on the first edge with start_i=1. At that same edge:
  - start_o=1, busy_o=1;
  - counters ia=ib=ic=0;
  - data_a_o=A[0], data_b_o=B[0], data_c_o=C[0].
- STREAM, each edge:
  - ia, ib and ic each increment, saturating at 3, 3 and MAX_DIM*MAX_DIM respectively.
  - data_a_o = A[ia+1] if ia+1 <= n_dim_i, else 0.
  - data_b_o = B[ib+1] if ib+1 <= m_dim_i, else 0.
  - data_c_o = C[ic+1] if ic+1 <= (n_dim_i+1)*(m_dim_i+1)-1, else 0.
  - Result: word j is presented during the j-th cycle after start_o rises.
- STREAM -> FLUSH when finish_i=1. At that edge: start_o=0, stream outputs=0, done_o=1 for one cycle.
- FLUSH -> IDLE after one cycle, busy_o=0. A still-high start_i does not restart; start_i must go low first.
- STREAM with start_i=0 (abort): go to IDLE at that edge with start_o=0, busy_o=0, outputs=0, no done_o.
- Async reset mid-stream: everything clears immediately and storage contents are lost.
- Dimension inputs are sampled combinationally and must stay stable while busy_o=1.

Test Plan:
- Write A[0]=0x0201, A[1]=0x0403, B[0]=0x0605, B[1]=0x0807, C[0..3]=1,2,3,4; n=m=1; raise start_i -> start_o rises with data_a_o=0x0201, b=0x0605, c=1. Next cycles: a=0x0403, b=0x0807, c=2; then a=b=0, c=3; then c=4; then c=0.
- n=0, m=1 run -> data_a_o is 0 from the second cycle on; data_c_o streams C[0], C[1] then 0.
- During STREAM: host write to A plus simultaneous res_en_i to addr {idx=2, 5'b10000} with data 0x00AA -> wr_err_o pulses, A is unchanged, C[2]=0x00AA; a later read of C[2] returns 0x00AA one cycle after rd_en_i.
- finish_i pulse during STREAM -> start_o drops and done_o=1 on that edge; busy_o=0 one cycle later; start_i held high causes no restart.
- Drop start_i mid-stream, then separately assert rst_ni=0 mid-stream:
  - Abort: returns to IDLE with no done_o.
  - Reset: all outputs and storage clear asynchronously.
- Host write to address 5'b00011 and to an A index of 2 -> wr_err_o pulses each time; reads of those addresses return 0.
